spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter: RD_LATENCY, 2, clock edges from the edge after the last MOSI bit to the first MISO sample; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  transaction request; sampled only in IDLE.
REQ-005 cmd_in  input  10  frame to send: [9:8] command, [7:0] address/data.
REQ-006 busy  output  1  high whenever state is not IDLE.
REQ-007 done  output  1  one-cycle pulse at end of every transaction.
REQ-008 rx_data  output  8  byte received on a read-data command.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data is updated.
REQ-010 SS_n  output  1  slave select, active-low.
REQ-011 MOSI  output  1  serial data to the slave, MSB first.
REQ-012 MISO  input  1  serial data from the slave, MSB first.

Function
REQ-013 States SHALL be IDLE, SHIFT, WAIT_RD and RECV, held in a registered FSM; all outputs SHALL be registered.
REQ-014 Accept edge E0: start=1 while in IDLE; cmd_in latched, SS_n<=0, MOSI<=cmd[9], state<=SHIFT, bit counter<=9.
REQ-015 Edges E1..E9: MOSI<=cmd[8] down to cmd[0], one bit per edge; each bit held for one full cycle.
REQ-016 Edge E10, cmd[9:8]!=2'b11: state<=IDLE, SS_n<=1, MOSI<=0, done<=1 for one cycle; rx_data and rx_valid unchanged.
REQ-017 Edge E10, cmd[9:8]==2'b11: state<=WAIT_RD, MOSI<=0, SS_n stays 0, wait counter loaded.
REQ-018 WAIT_RD: first MISO sample taken at edge E(9+RD_LATENCY+1), i.e. RD_LATENCY edges after E10; state<=RECV on that edge.
REQ-019 RECV: MISO shifted in MSB first on 8 consecutive edges, the first being the WAIT_RD exit edge.
REQ-020 On the 8th sample edge: rx_data<=assembled byte, rx_valid<=1, done<=1 (both one cycle), SS_n<=1, state<=IDLE.
REQ-021 start while busy=1 SHALL be ignored, with no queuing; changes on cmd_in after E0 SHALL not affect the frame in flight.
REQ-022 start in the cycle done is high SHALL be accepted at the next edge, giving SS_n high for exactly one cycle between frames, the required minimum.
REQ-023 MOSI SHALL be 0 whenever SS_n=1 or state is WAIT_RD/RECV; MISO SHALL be ignored outside RECV and the WAIT_RD exit edge.
REQ-024 Counters SHALL not wrap: the bit counter runs 9..0 and the receive counter runs 7..0, and both reload on entry.

Reset
REQ-025 rst_n low SHALL immediately force: state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rx_valid=0, rx_data=8'h00, and all counters 0.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no done/rx_valid pulse; after release, the first start is handled as a fresh frame.
REQ-027 start high during the reset-release cycle SHALL be ignored; only starts sampled on an edge with rst_n=1 are accepted.

Verification
REQ-028 Write-addr: cmd_in=10'b00_1010_0101, start pulse -> SS_n low 10 cycles, MOSI=0,0,1,0,1,0,0,1,0,1, done at E10, rx_valid stays 0.
REQ-029 Read-data, RD_LATENCY=2: cmd_in=10'b11_0000_0000, slave model drives 8'hC3 -> samples at E12..E19, rx_data=8'hC3, rx_valid=done=1 at E19, SS_n high after E19.
REQ-030 Back-to-back: start held high continuously for two frames (10'h2FF, then 10'h100) -> SS_n high exactly one cycle between frames, two done pulses.
REQ-031 start pulses at E3 and E7 of a write frame -> ignored, single done, MOSI pattern unchanged.
REQ-032 rst_n low at E15 of a read frame -> SS_n=1 and busy=0 immediately, no rx_valid, rx_data=8'h00; the next read of 8'h5A completes correctly.
REQ-033 Sweep RD_LATENCY in {1,15} with read-data 8'h81 -> first sample at E11 and E25 respectively, rx_data=8'h81.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: shifts out a 10-bit command frame MSB first and, for read-data
// commands, waits RD_LATENCY edges and then shifts in one byte from MISO.
module spi_master #(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [9:0] cmd_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_RD = 2'd2,
    RECV    = 2'd3
  } state_t;

  localparam logic [1:0] CMD_READ  = 2'b11;
  // The exit edge of WAIT_RD is itself the first sample edge, hence the minus one.
  localparam logic [3:0] WAIT_LOAD = 4'(RD_LATENCY - 1);

  state_t      state_r;
  logic [9:0]  cmd_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  wait_cnt_r;
  logic [2:0]  rcv_cnt_r;
  logic [6:0]  shift_r;

  // Frame sequencer: all state and every output are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cmd_r      <= 10'd0;
      bit_cnt_r  <= 4'd0;
      wait_cnt_r <= 4'd0;
      rcv_cnt_r  <= 3'd0;
      shift_r    <= 7'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      SS_n       <= 1'b1;
      MOSI       <= 1'b0;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            cmd_r     <= cmd_in;
            SS_n      <= 1'b0;
            MOSI      <= cmd_in[9];
            bit_cnt_r <= 4'd9;
            busy      <= 1'b1;
            state_r   <= SHIFT;
          end else begin
            MOSI <= 1'b0;
          end
        end
        SHIFT: begin
          if (bit_cnt_r == 4'd0) begin
            MOSI <= 1'b0;
            if (cmd_r[9:8] == CMD_READ) begin
              wait_cnt_r <= WAIT_LOAD;
              rcv_cnt_r  <= 3'd7;
              state_r    <= WAIT_RD;
            end else begin
              SS_n    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state_r <= IDLE;
            end
          end else begin
            MOSI      <= cmd_r[bit_cnt_r - 4'd1];
            bit_cnt_r <= bit_cnt_r - 4'd1;
          end
        end
        WAIT_RD: begin
          MOSI <= 1'b0;
          if (wait_cnt_r == 4'd0) begin
            shift_r   <= {6'd0, MISO};
            rcv_cnt_r <= rcv_cnt_r - 3'd1;
            state_r   <= RECV;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        RECV: begin
          MOSI <= 1'b0;
          if (rcv_cnt_r == 3'd0) begin
            rx_data  <= {shift_r, MISO};
            rx_valid <= 1'b1;
            done     <= 1'b1;
            SS_n     <= 1'b1;
            busy     <= 1'b0;
            state_r  <= IDLE;
          end else begin
            shift_r   <= {shift_r[5:0], MISO};
            rcv_cnt_r <= rcv_cnt_r - 3'd1;
          end
        end
        default: begin
          SS_n    <= 1'b1;
          MOSI    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (RD_LATENCY 2, 1, 15) checked every
// cycle against a frame-timeline model, plus literal expectations per scenario.
module tb_spi_master;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [9:0] cmd_in;
  logic [2:0] ss_n, mosi, busy, done, rx_valid, miso;
  logic [7:0] rx_data [3];
  logic [7:0] sbyte   [3];

  int total = 0;
  int bad   = 0;

  spi_master #(.RD_LATENCY(2))  u_dut0 (.clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in),
    .busy(busy[0]), .done(done[0]), .rx_data(rx_data[0]), .rx_valid(rx_valid[0]),
    .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0]));
  spi_master #(.RD_LATENCY(1))  u_dut1 (.clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in),
    .busy(busy[1]), .done(done[1]), .rx_data(rx_data[1]), .rx_valid(rx_valid[1]),
    .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1]));
  spi_master #(.RD_LATENCY(15)) u_dut2 (.clk(clk), .rst_n(rst_n), .start(start), .cmd_in(cmd_in),
    .busy(busy[2]), .done(done[2]), .rx_data(rx_data[2]), .rx_valid(rx_valid[2]),
    .SS_n(ss_n[2]), .MOSI(mosi[2]), .MISO(miso[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic bit is_read(input logic [9:0] c);
    return c[9:8] == 2'b11;
  endfunction

  // Edge index (counted from the accept edge E0) at which the frame ends.
  function automatic int end_edge(input logic [9:0] c, input int d);
    return is_read(c) ? 17 + lat_of(d) : 10;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Frame-timeline model: per instance, whether a frame is in flight and how many edges since E0.
  bit         m_active [3] = '{1'b0, 1'b0, 1'b0};
  int         m_k      [3] = '{0, 0, 0};
  logic [9:0] m_cmd    [3] = '{10'd0, 10'd0, 10'd0};
  logic [7:0] m_rx     [3] = '{8'h00, 8'h00, 8'h00};
  bit         m_done   [3] = '{1'b0, 1'b0, 1'b0};
  bit         m_rv     [3] = '{1'b0, 1'b0, 1'b0};

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_active[d] = 1'b0; m_k[d] = 0; m_rx[d] = 8'h00; m_done[d] = 1'b0; m_rv[d] = 1'b0;
      end else begin
        m_done[d] = 1'b0;
        m_rv[d]   = 1'b0;
        if (!m_active[d]) begin
          if (start) begin
            m_active[d] = 1'b1; m_k[d] = 0; m_cmd[d] = cmd_in;
          end
        end else begin
          m_k[d]++;
          if (m_k[d] == end_edge(m_cmd[d], d)) begin
            m_active[d] = 1'b0;
            m_done[d]   = 1'b1;
            if (is_read(m_cmd[d])) begin
              m_rv[d] = 1'b1;
              m_rx[d] = sbyte[d];
            end
          end
        end
      end
    end
  end

  function automatic logic [12:0] model_vec(input int d);
    logic s, m, b;
    if (m_active[d]) begin
      s = 1'b0; b = 1'b1;
      m = (m_k[d] <= 9) ? m_cmd[d][9 - m_k[d]] : 1'b0;
    end else begin
      s = 1'b1; b = 1'b0; m = 1'b0;
    end
    return {s, m, b, m_done[d], m_rv[d], m_rx[d]};
  endfunction

  // Slave: presents bit 7-j so it is stable at sample edge E(10+L+j); drives 1 elsewhere.
  initial begin
    miso = 3'b111;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int j;
        j = m_k[d] + 1 - 10 - lat_of(d);
        if (m_active[d] && is_read(m_cmd[d]) && j >= 0 && j <= 7)
          miso[d] = sbyte[d][7 - j];
        else
          miso[d] = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output of every instance against the model.
  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("cycle_dut%0d", d),
            32'({ss_n[d], mosi[d], busy[d], done[d], rx_valid[d], rx_data[d]}),
            32'(model_vec(d)));
  end

  // Observers feeding the literal checks: MOSI capture, SS_n run lengths, pulse counts.
  int         run [3] = '{0, 0, 0};
  int         hi  [3] = '{0, 0, 0};
  int         last_run [3] = '{0, 0, 0};
  int         gap [3] = '{0, 0, 0};
  int         lat [3] = '{0, 0, 0};
  int         done_tot [3] = '{0, 0, 0};
  int         rv_tot [3] = '{0, 0, 0};
  logic [9:0] cap [3] = '{10'd0, 10'd0, 10'd0};

  initial forever begin
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      if (ss_n[d] === 1'b0) begin
        if (hi[d] > 0) begin gap[d] = hi[d]; hi[d] = 0; end
        if (run[d] < 10) cap[d] = {cap[d][8:0], mosi[d]};
        run[d]++;
      end else begin
        if (run[d] > 0) begin last_run[d] = run[d]; run[d] = 0; end
        hi[d]++;
      end
      if (rx_valid[d] === 1'b1) begin lat[d] = last_run[d]; rv_tot[d]++; end
      if (done[d] === 1'b1) done_tot[d]++;
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 3'b000 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy !== 3'b000), 32'd0);
    @(negedge clk);
    #1;
  endtask

  task automatic send(input logic [9:0] c);
    @(negedge clk);
    cmd_in = c;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  initial begin
    int d0, v0, n;
    rst_n = 1'b1; start = 1'b0; cmd_in = 10'd0;
    sbyte = '{8'h00, 8'h00, 8'h00};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", 32'({ss_n[0], mosi[0], busy[0], done[0], rx_valid[0], rx_data[0]}), 32'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write-address frame.
    d0 = done_tot[0]; v0 = rv_tot[0];
    send(10'b00_1010_0101);
    wait_idle();
    check("write_mosi", 32'(cap[0]), 32'h0A5);
    check("write_ss_low", last_run[0], 10);
    check("write_done", done_tot[0] - d0, 1);
    check("write_no_rv", rv_tot[0] - v0, 0);

    // Read-data frame on all three latencies.
    sbyte = '{8'hC3, 8'h81, 8'h81};
    repeat (2) @(negedge clk);
    send(10'b11_0000_0000);
    wait_idle();
    check("read_rx_l2", 32'(rx_data[0]), 32'hC3);
    check("read_rx_l1", 32'(rx_data[1]), 32'h81);
    check("read_rx_l15", 32'(rx_data[2]), 32'h81);
    check("read_len_l2", lat[0], 19);
    check("read_len_l1", lat[1], 18);
    check("read_len_l15", lat[2], 32);

    // Back-to-back writes with start held; cmd_in changes after E0.
    d0 = done_tot[0];
    @(negedge clk);
    cmd_in = 10'h2FF; start = 1'b1;
    @(negedge clk);
    cmd_in = 10'h100;
    n = 0;
    while (done[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("b2b_timeout", 32'(done[0]), 32'd1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("b2b_gap", gap[0], 1);
    check("b2b_done", done_tot[0] - d0, 2);
    check("b2b_mosi2", 32'(cap[0]), 32'h100);

    // Start pulses at E3 and E7 of a write frame must be ignored.
    d0 = done_tot[0];
    send(10'b10_0110_1001);
    cmd_in = 10'h3FF;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    check("ign_done", done_tot[0] - d0, 1);
    check("ign_mosi", 32'(cap[0]), 32'h269);

    // Reset at E15 of a read aborts it; a following read completes.
    sbyte = '{8'h5A, 8'h5A, 8'h5A};
    d0 = done_tot[0]; v0 = rv_tot[0];
    send(10'b11_0000_0000);
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outputs", 32'({ss_n[0], mosi[0], busy[0], done[0], rx_valid[0], rx_data[0]}), 32'h1000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("abort_no_rv", rv_tot[0] - v0, 0);
    check("abort_no_done", done_tot[0] - d0, 0);
    send(10'b11_0000_0000);
    wait_idle();
    check("after_abort_rx", 32'(rx_data[0]), 32'h5A);
    check("after_abort_rx_l15", 32'(rx_data[2]), 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
